// File: rtl/raster_tile_walker.sv
// raster_tile_walker: walks every block of a rasterizer tile in raster order,
// trivially rejects blocks lying wholly outside any of the three edges, and
// emits surviving blocks with their edge equations rebased to the block origin.
// Edge values are stepped incrementally (shift + add only, no multipliers).
//
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   valid_in        tile valid; accepted when ready_in is high
//   pid_in          primitive id
//   xloc_in/yloc_in tile origin
//   edges_in        [i][0]=a, [i][1]=b, [i][2]=c (value at tile origin)
//   ready_in        high only while idle
//   valid_out       accepted block valid, held until ready_out
//   pid_out         primitive id of the block
//   xloc_out/yloc_out block origin
//   edges_out       a/b unchanged, [i][2]=edge value at block origin
//   ready_out       downstream ready
//   busy            walk in progress or output register occupied

`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module raster_tile_walker #(
    parameter int unsigned TILE_LOGSIZE  = 5,
    parameter int unsigned BLOCK_LOGSIZE = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         valid_in,
    input  logic [`VX_RASTER_PID_BITS-1:0]               pid_in,
    input  logic [`VX_RASTER_DIM_BITS-1:0]               xloc_in,
    input  logic [`VX_RASTER_DIM_BITS-1:0]               yloc_in,
    input  logic [2:0][2:0][`RASTER_DATA_BITS-1:0]       edges_in,
    output logic                                         ready_in,
    output logic                                         valid_out,
    output logic [`VX_RASTER_PID_BITS-1:0]               pid_out,
    output logic [`VX_RASTER_DIM_BITS-1:0]               xloc_out,
    output logic [`VX_RASTER_DIM_BITS-1:0]               yloc_out,
    output logic [2:0][2:0][`RASTER_DATA_BITS-1:0]       edges_out,
    input  logic                                         ready_out,
    output logic                                         busy
);

    localparam int unsigned PID_W  = `VX_RASTER_PID_BITS;
    localparam int unsigned DIM_W  = `VX_RASTER_DIM_BITS;
    localparam int unsigned DATA_W = `RASTER_DATA_BITS;
    localparam int unsigned NB_W   = TILE_LOGSIZE - BLOCK_LOGSIZE;
    localparam logic [NB_W-1:0] LAST_B = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WALK  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched primitive
    logic [PID_W-1:0]                  pid_q, pid_d;
    logic [DIM_W-1:0]                  xloc_q, xloc_d;
    logic [DIM_W-1:0]                  yloc_q, yloc_d;
    logic [2:0][2:0][DATA_W-1:0]       edges_q, edges_d;

    // Walk state
    logic [2:0][DATA_W-1:0]            ext_q, ext_d;
    logic [2:0][DATA_W-1:0]            row_e_q, row_e_d;
    logic [2:0][DATA_W-1:0]            cur_e_q, cur_e_d;
    logic [NB_W-1:0]                   bx_q, bx_d;
    logic [NB_W-1:0]                   by_q, by_d;

    // Output register
    logic                              out_valid_q, out_valid_d;
    logic [PID_W-1:0]                  out_pid_q, out_pid_d;
    logic [DIM_W-1:0]                  out_x_q, out_x_d;
    logic [DIM_W-1:0]                  out_y_q, out_y_d;
    logic [2:0][2:0][DATA_W-1:0]       out_edges_q, out_edges_d;
    logic                              ready_q, ready_d;
    logic                              busy_q, busy_d;

    // Per-edge arithmetic helpers
    logic [2:0][DATA_W-1:0]            pos_a, pos_b;
    logic [2:0][DATA_W-1:0]            test_sum;
    logic [2:0][DATA_W-1:0]            next_row;
    logic                              block_hit;
    logic                              out_can_load;

    // Clamped coefficients, trivial-reject test sum and next-row start value
    always_comb begin
        pos_a     = '0;
        pos_b     = '0;
        test_sum  = '0;
        next_row  = '0;
        block_hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pos_a[i]    = edges_q[i][0][DATA_W-1] ? '0 : edges_q[i][0];
            pos_b[i]    = edges_q[i][1][DATA_W-1] ? '0 : edges_q[i][1];
            // ext is the largest increase of the edge over the block's far corner
            test_sum[i] = cur_e_q[i] + ext_q[i];
            next_row[i] = row_e_q[i] + (edges_q[i][1] << BLOCK_LOGSIZE);
            if (test_sum[i][DATA_W-1]) begin
                block_hit = 1'b0;
            end
        end
    end

    assign out_can_load = !out_valid_q || ready_out;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        pid_d       = pid_q;
        xloc_d      = xloc_q;
        yloc_d      = yloc_q;
        edges_d     = edges_q;
        ext_d       = ext_q;
        row_e_d     = row_e_q;
        cur_e_d     = cur_e_q;
        bx_d        = bx_q;
        by_d        = by_q;
        out_valid_d = out_valid_q;
        out_pid_d   = out_pid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        out_edges_d = out_edges_q;

        // Output register drains on a downstream fire
        if (out_valid_q && ready_out) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (valid_in && ready_q) begin
                    pid_d   = pid_in;
                    xloc_d  = xloc_in;
                    yloc_d  = yloc_in;
                    edges_d = edges_in;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                for (int i = 0; i < 3; i++) begin
                    ext_d[i]   = (pos_a[i] << BLOCK_LOGSIZE) - pos_a[i]
                               + (pos_b[i] << BLOCK_LOGSIZE) - pos_b[i];
                    row_e_d[i] = edges_q[i][2];
                    cur_e_d[i] = edges_q[i][2];
                end
                bx_d    = '0;
                by_d    = '0;
                state_d = S_WALK;
            end

            S_WALK: begin
                if (out_can_load) begin
                    if (block_hit) begin
                        out_valid_d = 1'b1;
                        out_pid_d   = pid_q;
                        out_x_d     = xloc_q + (DIM_W'(bx_q) << BLOCK_LOGSIZE);
                        out_y_d     = yloc_q + (DIM_W'(by_q) << BLOCK_LOGSIZE);
                        for (int i = 0; i < 3; i++) begin
                            out_edges_d[i][0] = edges_q[i][0];
                            out_edges_d[i][1] = edges_q[i][1];
                            out_edges_d[i][2] = cur_e_q[i];
                        end
                    end

                    if (bx_q != LAST_B) begin
                        bx_d = bx_q + 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            cur_e_d[i] = cur_e_q[i] + (edges_q[i][0] << BLOCK_LOGSIZE);
                        end
                    end else begin
                        bx_d = '0;
                        by_d = by_q + 1'b1;
                        for (int i = 0; i < 3; i++) begin
                            row_e_d[i] = next_row[i];
                            cur_e_d[i] = next_row[i];
                        end
                        if (by_q == LAST_B) begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE) || out_valid_d;
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pid_q       <= '0;
            xloc_q      <= '0;
            yloc_q      <= '0;
            edges_q     <= '0;
            ext_q       <= '0;
            row_e_q     <= '0;
            cur_e_q     <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            out_valid_q <= 1'b0;
            out_pid_q   <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_edges_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pid_q       <= pid_d;
            xloc_q      <= xloc_d;
            yloc_q      <= yloc_d;
            edges_q     <= edges_d;
            ext_q       <= ext_d;
            row_e_q     <= row_e_d;
            cur_e_q     <= cur_e_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            out_valid_q <= out_valid_d;
            out_pid_q   <= out_pid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            out_edges_q <= out_edges_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign ready_in  = ready_q;
    assign valid_out = out_valid_q;
    assign pid_out   = out_pid_q;
    assign xloc_out  = out_x_q;
    assign yloc_out  = out_y_q;
    assign edges_out = out_edges_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_raster_tile_walker.sv
// Scoreboard bench for raster_tile_walker: a direct plane-equation model
// pushes the expected surviving blocks of each tile; a monitor pops and
// compares on every output handshake.

`ifndef VX_RASTER_PID_BITS
`define VX_RASTER_PID_BITS 16
`endif
`ifndef VX_RASTER_DIM_BITS
`define VX_RASTER_DIM_BITS 16
`endif
`ifndef RASTER_DATA_BITS
`define RASTER_DATA_BITS 32
`endif

module tb_raster_tile_walker;

    localparam int unsigned TL    = 5;
    localparam int unsigned BL    = 2;
    localparam int unsigned NB    = 1 << (TL - BL);
    localparam int unsigned BS    = 1 << BL;
    localparam int unsigned PID_W = `VX_RASTER_PID_BITS;
    localparam int unsigned DIM_W = `VX_RASTER_DIM_BITS;
    localparam int unsigned DW    = `RASTER_DATA_BITS;
    localparam int unsigned BLK_W = PID_W + 2 * DIM_W + 9 * DW;

    typedef logic [2:0][2:0][DW-1:0] edges_t;
    typedef logic [BLK_W-1:0]        blk_t;

    logic              clk;
    logic              reset;
    logic              valid_in;
    logic [PID_W-1:0]  pid_in;
    logic [DIM_W-1:0]  xloc_in;
    logic [DIM_W-1:0]  yloc_in;
    edges_t            edges_in;
    logic              ready_in;
    logic              valid_out;
    logic [PID_W-1:0]  pid_out;
    logic [DIM_W-1:0]  xloc_out;
    logic [DIM_W-1:0]  yloc_out;
    edges_t            edges_out;
    logic              ready_out;
    logic              busy;

    raster_tile_walker #(
        .TILE_LOGSIZE (TL),
        .BLOCK_LOGSIZE(BL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_in (valid_in),
        .pid_in   (pid_in),
        .xloc_in  (xloc_in),
        .yloc_in  (yloc_in),
        .edges_in (edges_in),
        .ready_in (ready_in),
        .valid_out(valid_out),
        .pid_out  (pid_out),
        .xloc_out (xloc_out),
        .yloc_out (yloc_out),
        .edges_out(edges_out),
        .ready_out(ready_out),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad   = 0;
    int   n_pop   = 0;
    blk_t sb_q[$];
    int   rdy_mode   = 0;   // 0: always ready, 1: random, 2: manual
    logic rdy_manual = 1'b1;

    task automatic chk(input string tag, input blk_t obs, input blk_t exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Expected blocks from the closed-form plane equation at each block origin
    task automatic push_model(input logic [PID_W-1:0] pid, input logic [DIM_W-1:0] x,
                              input logic [DIM_W-1:0] y, input edges_t e);
        int     a, b, c, ev, ext;
        bit     ok;
        edges_t ee;
        for (int by = 0; by < int'(NB); by++) begin
            for (int bx = 0; bx < int'(NB); bx++) begin
                ok = 1'b1;
                ee = e;
                for (int i = 0; i < 3; i++) begin
                    a   = int'($signed(e[i][0]));
                    b   = int'($signed(e[i][1]));
                    c   = int'($signed(e[i][2]));
                    ev  = c + a * (bx * int'(BS)) + b * (by * int'(BS));
                    ext = (a > 0 ? a : 0) * (int'(BS) - 1) + (b > 0 ? b : 0) * (int'(BS) - 1);
                    if (ev + ext < 0) ok = 1'b0;
                    ee[i][2] = DW'(ev);
                end
                if (ok) begin
                    sb_q.push_back({pid, DIM_W'(int'(x) + bx * int'(BS)),
                                    DIM_W'(int'(y) + by * int'(BS)), ee});
                end
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_in && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) chk("ready_timeout", BLK_W'(ready_in), BLK_W'(1));
    endtask

    // Drives one tile; returns just after the accepting clock edge
    task automatic send(input logic [PID_W-1:0] pid, input logic [DIM_W-1:0] x,
                        input logic [DIM_W-1:0] y, input edges_t e);
        @(negedge clk);
        wait_ready();
        push_model(pid, x, y, e);
        pid_in   = pid;
        xloc_in  = x;
        yloc_in  = y;
        edges_in = e;
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || !ready_in) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk(tag, BLK_W'(sb_q.size()), '0);
    endtask

    function automatic edges_t mk_edges(input int a0, input int b0, input int c0,
                                        input int a1, input int b1, input int c1,
                                        input int a2, input int b2, input int c2);
        edges_t e;
        e[0][0] = DW'(a0); e[0][1] = DW'(b0); e[0][2] = DW'(c0);
        e[1][0] = DW'(a1); e[1][1] = DW'(b1); e[1][2] = DW'(c1);
        e[2][0] = DW'(a2); e[2][1] = DW'(b2); e[2][2] = DW'(c2);
        return e;
    endfunction

    // Downstream ready generator
    initial begin
        ready_out = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       ready_out = 1'b1;
                1:       ready_out = 1'($urandom_range(0, 1));
                default: ready_out = rdy_manual;
            endcase
        end
    end

    // Output monitor: compare on fire, check stability while stalled
    initial begin
        blk_t act;
        bit   prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) chk("hold_valid", BLK_W'(valid_out), BLK_W'(1));
                prev_stall = 1'b0;
                if (valid_out) begin
                    act = {pid_out, xloc_out, yloc_out, edges_out};
                    if (sb_q.size() == 0) begin
                        chk("extra_blk", BLK_W'(1), BLK_W'(0));
                    end else if (ready_out) begin
                        chk("blk", act, sb_q.pop_front());
                        n_pop++;
                    end else begin
                        chk("held_blk", act, sb_q[0]);
                        prev_stall = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        edges_t e;
        int     n;
        reset    = 1'b0;
        valid_in = 1'b0;
        pid_in   = '0;
        xloc_in  = '0;
        yloc_in  = '0;
        edges_in = '0;

        repeat (3) @(negedge clk);
        chk("rst_valid", BLK_W'(valid_out), '0);
        chk("rst_busy", BLK_W'(busy), '0);
        chk("rst_data", {pid_out, xloc_out, yloc_out, edges_out}, '0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ready", BLK_W'(ready_in), BLK_W'(1));

        // Full cover with exact walk timing
        e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(16'd7, 16'd32, 16'd64, e);
        repeat (64) @(posedge clk);
        #1;
        chk("idle_early", BLK_W'(ready_in), '0);
        @(posedge clk);
        #1;
        chk("idle_at_65", BLK_W'(ready_in), BLK_W'(1));
        drain("drain_cover");
        chk("busy_after_cover", BLK_W'(busy), '0);

        // Full reject: nothing emitted, still walks the whole tile
        e = mk_edges(0, 0, -1, 0, 0, -1, 0, 0, -1);
        send(16'd3, 16'd0, 16'd0, e);
        repeat (64) @(posedge clk);
        #1;
        chk("rej_idle_early", BLK_W'(ready_in), '0);
        chk("rej_busy_walk", BLK_W'(busy), BLK_W'(1));
        @(posedge clk);
        #1;
        chk("rej_idle_at_65", BLK_W'(ready_in), BLK_W'(1));
        chk("rej_busy_done", BLK_W'(busy), '0);
        drain("drain_reject");

        // Half-plane: only x in {0,4,8,12} survive
        e = mk_edges(-1, 0, 15, 0, 0, 1, 0, 0, 1);
        send(16'd5, 16'd0, 16'd0, e);
        drain("drain_half");

        // Backpressure right after the first valid
        rdy_mode   = 2;
        rdy_manual = 1'b1;
        e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(16'd7, 16'd32, 16'd64, e);
        n = 0;
        while (!valid_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_first_valid", BLK_W'(valid_out), BLK_W'(1));
        rdy_manual = 1'b0;
        repeat (11) @(negedge clk);
        rdy_manual = 1'b1;
        drain("drain_bp");

        // Back-to-back primitives under random backpressure
        rdy_mode = 1;
        e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(16'd1, 16'd96, 16'd32, e);
        send(16'd2, 16'd128, 16'd32, e);
        drain("drain_b2b");

        // Random sloped edges, exercising row stepping with nonzero b
        for (int t = 0; t < 4; t++) begin
            e = mk_edges(int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8,
                         int'($urandom_range(0, 120)) - 40,
                         int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8,
                         int'($urandom_range(0, 120)) - 40,
                         int'($urandom_range(0, 16)) - 8, int'($urandom_range(0, 16)) - 8,
                         int'($urandom_range(0, 120)) - 40);
            send(PID_W'(10 + t), DIM_W'(32 * $urandom_range(0, 30)),
                 DIM_W'(32 * $urandom_range(0, 30)), e);
        end
        drain("drain_rand");

        // Reset in the middle of a walk
        rdy_mode = 0;
        n = n_pop + 20;
        e = mk_edges(0, 0, 1, 0, 0, 1, 0, 0, 1);
        send(16'd9, 16'd0, 16'd0, e);
        while (n_pop < n) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", BLK_W'(valid_out), '0);
        chk("midrst_busy", BLK_W'(busy), '0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready", BLK_W'(ready_in), BLK_W'(1));
        e = mk_edges(-1, 0, 15, 0, 0, 1, 0, 0, 1);
        send(16'd4, 16'd64, 16'd0, e);
        drain("drain_after_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/raster_tile_walker.md
Name: raster_tile_walker

Overview:
- Sits directly downstream of the rasterizer memory unit and consumes its (pid, tile xloc/yloc, 3x3 edge coefficients) stream.
- Walks every block inside the tile in raster order and trivially rejects blocks that lie wholly outside any edge.
- Emits each surviving block with its edge equations rebased to the block origin, for the quad/fragment stage.
- Uses incremental stepping only: shifts and adds, no multipliers.

Parameters:
- TILE_LOGSIZE, 5, log2 of tile edge in pixels.
- BLOCK_LOGSIZE, 2, log2 of block edge in pixels; must be less than TILE_LOGSIZE.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- valid_in  in  1  primitive/tile valid
- pid_in  in  `VX_RASTER_PID_BITS  primitive id
- xloc_in  in  `VX_RASTER_DIM_BITS  tile origin x
- yloc_in  in  `VX_RASTER_DIM_BITS  tile origin y
- edges_in  in  [2:0][2:0][`RASTER_DATA_BITS]  edge i: [i][0]=a, [i][1]=b, [i][2]=c, where c is the value at the tile origin
- ready_in  out  1  accept input
- valid_out  out  1  accepted block valid
- pid_out  out  `VX_RASTER_PID_BITS  primitive id
- xloc_out  out  `VX_RASTER_DIM_BITS  block origin x
- yloc_out  out  `VX_RASTER_DIM_BITS  block origin y
- edges_out  out  [2:0][2:0][`RASTER_DATA_BITS]  a and b unchanged; [i][2] is the edge value at the block origin
- ready_out  in  1  downstream ready
- busy  out  1  state != IDLE or valid_out

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; valid_out=0; busy=0; ready_in=1 once released.
  - Data outputs reset to 0.
  - Asserting reset mid-walk aborts the walk; the in-flight primitive is dropped.
- Derived constants:
  - BS = 1<<BLOCK_LOGSIZE.
  - NB = 1<<(TILE_LOGSIZE-BLOCK_LOGSIZE) blocks per side; NB*NB blocks per tile.
- States IDLE, SETUP, WALK.
- IDLE:
  - ready_in=1.
  - On valid_in&&ready_in, latch all inputs and go to SETUP.
- SETUP (1 cycle):
  - For each edge, ext_i = (ap<<BLOCK_LOGSIZE)-ap + (bp<<BLOCK_LOGSIZE)-bp, where ap=max(a,0) and bp=max(b,0) (signed).
  - row_e_i=c_i, cur_e_i=c_i; bx=by=0.
  - Go to WALK.
- WALK: tests one block per cycle whenever the output register can accept (~valid_out || ready_out); otherwise it holds all state.
  - Accept iff for all i: (cur_e_i + ext_i) >= 0, signed 32-bit.
  - Accepted block: load the output register with valid_out=1, xloc=xloc_t+(bx<<BLOCK_LOGSIZE), yloc=yloc_t+(by<<BLOCK_LOGSIZE), edges [i][2]=cur_e_i.
  - Rejected block: valid_out clears if it fired this cycle.
  - Step within a row (bx<NB-1): bx++, cur_e_i += a_i<<BLOCK_LOGSIZE.
  - Row end: bx=0, by++, row_e_i += b_i<<BLOCK_LOGSIZE, cur_e_i = row_e_i + b_i<<BLOCK_LOGSIZE (same-cycle value).
  - On the last block (bx=by=NB-1), go to IDLE after the test.
- Latency: input fire to first block test is 2 cycles; a tested block appears on valid_out the next cycle.
- With no stalls, the walk takes exactly 1+NB*NB cycles after the input fire.
- Output handshake:
  - valid_out and its data stay stable until ready_out.
  - A fire with a simultaneous new accept reloads the register in the same cycle; there are no bubbles.
- ready_in is high only in IDLE.
  - IDLE may accept a new primitive while the last block is still held in the output register.
  - Blocks leave in order; no reordering across primitives.
- Arithmetic:
  - All edge arithmetic is two's-complement `RASTER_DATA_BITS wide; overflow wraps and is not detected.
  - Coordinate adds wrap at `VX_RASTER_DIM_BITS.
- Edge cases:
  - A fully rejected tile emits nothing and still returns to IDLE after the full walk.
  - a=b=0 gives ext=0.

Test Plan:
- Full cover: tile (32,64), pid 7, all edges a=b=0, c=1 → 64 outputs in raster order, x=32..60 step 4 and y=64..92 step 4; edges[i][2]=1; IDLE 65 cycles after fire.
- Full reject: all edges a=b=0, c=-1 → no valid_out; ready_in returns high 65 cycles after fire; busy low after that.
- Half-plane: tile (0,0), edge0 a=-1, b=0, c=15, other edges all-accept → 32 outputs, x ∈ {0,4,8,12} per row; block x=12 has edges_out[0][2]=3; x=16 is rejected.
- Backpressure: full-cover case with ready_out low for 10 cycles after the first valid → valid_out held, data unchanged, all 64 blocks delivered exactly once in order.
- Back-to-back primitives pid 1 then pid 2: the second input is accepted while pid 1's last block is held → pid 1's blocks all precede pid 2's blocks.
- Reset asserted mid-walk at block 20 → valid_out=0 and busy=0 immediately; after release ready_in=1 and a new primitive walks from block 0.
